// File: rtl/sorteador_papeis.sv
// -----------------------------------------------------------------------------
// sorteador_papeis
// Role-dealing engine for PoliLobinho. A seed is captured on a button press and
// loaded into a 16-bit Fibonacci LFSR. The LFSR then places N_LOBOS wolves among
// N_JOGADORES players by rejection sampling, and a reveal pointer steps through
// the players one `passa` pulse at a time.
//
// Configuration macro:
//   SORTEIO_SEMENTE_FIXA_EN - when defined, the seed is always SEMENTE_FIXA and
//                             the free-running seed counter is not built.
//
// Ports:
//   clock       in   single clock
//   reset       in   asynchronous, active-high
//   jogar       in   start/restart a game (1-cycle pulse)
//   botao       in   seed capture (1-cycle pulse)
//   passa       in   advance reveal pointer (1-cycle pulse)
//   jogo_atual  out  role mask, bit i = 1 means player i is a wolf
//   jogador_vez out  index of the player being revealed
//   papel_vez   out  role of jogador_vez while revealing
//   pronto      out  dealing complete (REVELA or FIM)
//   fim         out  every player has been revealed
//   db_estado   out  FSM state code
// -----------------------------------------------------------------------------
module sorteador_papeis #(
    parameter int          N_JOGADORES  = 10,
    parameter int          N_LOBOS      = 2,
    parameter logic [15:0] SEMENTE_FIXA = 16'hACE1,
    localparam int         IDX_W        = ($clog2(N_JOGADORES) > 1) ? $clog2(N_JOGADORES) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   jogar,
    input  logic                   botao,
    input  logic                   passa,
    output logic [N_JOGADORES-1:0] jogo_atual,
    output logic [IDX_W-1:0]       jogador_vez,
    output logic                   papel_vez,
    output logic                   pronto,
    output logic                   fim,
    output logic [4:0]             db_estado
);

    localparam int CNT_W = $clog2(N_JOGADORES + 1);
    localparam logic [IDX_W-1:0] ULTIMO  = IDX_W'(N_JOGADORES - 1);
    localparam logic [CNT_W-1:0] ALVO    = CNT_W'(N_LOBOS);
    localparam logic [N_JOGADORES-1:0] UM = {{(N_JOGADORES-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        INICIAL        = 3'd0,
        ESPERA_SEMENTE = 3'd1,
        SORTEIO        = 3'd2,
        REVELA         = 3'd3,
        FIM            = 3'd4
    } estado_t;

    estado_t                r_estado;
    logic [15:0]            r_lfsr;
    logic [N_JOGADORES-1:0] r_jogo_atual;
    logic [CNT_W-1:0]       r_conta_lobos;
    logic [IDX_W-1:0]       r_jogador_vez;
    logic                   r_pronto;
    logic                   r_fim;

    logic [15:0]            w_semente;
    logic [15:0]            w_lfsr_prox;
    logic [IDX_W-1:0]       w_cand;
    logic [N_JOGADORES-1:0] w_sel_cand;
    logic [N_JOGADORES-1:0] w_sel_vez;
    logic                   w_cand_ok;

`ifdef SORTEIO_SEMENTE_FIXA_EN
    assign w_semente = SEMENTE_FIXA;
`else
    // Free-running seed counter: the press timing of `botao` is the entropy.
    logic [15:0] r_cs;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_cs <= 16'd0;
        else       r_cs <= r_cs + 16'd1;
    end

    assign w_semente = r_cs;
`endif

    // Fibonacci LFSR, taps 16/14/13/11, shifted left with feedback into b0.
    assign w_lfsr_prox = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

    // Candidates past the last player shift out of the one-hot select, so the
    // explicit range test is what rejects them.
    assign w_cand     = r_lfsr[IDX_W-1:0];
    assign w_sel_cand = UM << w_cand;
    assign w_cand_ok  = ({{(32-IDX_W){1'b0}}, w_cand} < 32'(N_JOGADORES))
                     && ((r_jogo_atual & w_sel_cand) == '0)
                     && (r_conta_lobos < ALVO);

    assign w_sel_vez  = UM << r_jogador_vez;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado      <= INICIAL;
            r_lfsr        <= 16'h0001;
            r_jogo_atual  <= '0;
            r_conta_lobos <= '0;
            r_jogador_vez <= '0;
            r_pronto      <= 1'b0;
            r_fim         <= 1'b0;
        end else begin
            case (r_estado)
                INICIAL: begin
                    if (jogar) r_estado <= ESPERA_SEMENTE;
                end
                ESPERA_SEMENTE: begin
                    if (botao) begin
                        // A zero seed would freeze the LFSR forever.
                        r_lfsr   <= (w_semente == 16'd0) ? 16'h0001 : w_semente;
                        r_estado <= SORTEIO;
                    end
                end
                SORTEIO: begin
                    r_lfsr <= w_lfsr_prox;
                    if (r_conta_lobos == ALVO) begin
                        r_estado      <= REVELA;
                        r_jogador_vez <= '0;
                        r_pronto      <= 1'b1;
                    end else if (w_cand_ok) begin
                        r_jogo_atual  <= r_jogo_atual | w_sel_cand;
                        r_conta_lobos <= r_conta_lobos + CNT_W'(1);
                    end
                end
                REVELA: begin
                    if (passa) begin
                        if (r_jogador_vez == ULTIMO) begin
                            r_estado <= FIM;
                            r_fim    <= 1'b1;
                        end else begin
                            r_jogador_vez <= r_jogador_vez + IDX_W'(1);
                        end
                    end
                end
                FIM: begin
                    if (jogar) begin
                        r_estado      <= ESPERA_SEMENTE;
                        r_jogo_atual  <= '0;
                        r_conta_lobos <= '0;
                        r_jogador_vez <= '0;
                        r_pronto      <= 1'b0;
                        r_fim         <= 1'b0;
                    end
                end
                default: r_estado <= INICIAL;
            endcase
        end
    end

    assign jogo_atual  = r_jogo_atual;
    assign jogador_vez = r_jogador_vez;
    assign papel_vez   = (r_estado == REVELA) && ((r_jogo_atual & w_sel_vez) != '0);
    assign pronto      = r_pronto;
    assign fim         = r_fim;
    assign db_estado   = {2'b00, r_estado};

endmodule

// File: doc/sorteador_papeis.md
# sorteador_papeis

Parametrised role-dealing engine for the PoliLobinho werewolf game; successor to the fixed 10-player seed/dealing path. Captures a seed from a free-running counter on a button press, then places `N_LOBOS` wolves among `N_JOGADORES` players with a 16-bit LFSR and rejection sampling. It then steps a reveal pointer through the players on `passa`, and exposes the final role mask on `jogo_atual`. It sits between the top-level button inputs and the display/debug logic.

## Interface
- `N_JOGADORES`, default 10: number of players.
  - Legal range is 2..32.
- `N_LOBOS`, default 2: number of wolves.
  - Legal range is 1..`N_JOGADORES`-1.
- `SEMENTE_FIXA`, default 16'hACE1: seed used when `SORTEIO_SEMENTE_FIXA_EN` is defined.
- Derived width `IDX_W` = max(1, $clog2(`N_JOGADORES`)).

Ports:
- `clock` in 1: the single clock.
- `reset` in 1: asynchronous, active-high.
- `jogar` in 1: start or restart a game.
- `botao` in 1: seed capture.
- `passa` in 1: advance the reveal pointer.
- `jogo_atual` out `N_JOGADORES`: role mask. Bit i = 1 means player i is a wolf.
- `jogador_vez` out `IDX_W`: index of the player being revealed.
- `papel_vez` out 1: role of `jogador_vez`.
- `pronto` out 1: dealing is complete.
- `fim` out 1: all players have been revealed.
- `db_estado` out 5: FSM state code.

All inputs are single-cycle pulses, already synchronised and edge-detected upstream.

## Operation
States and `db_estado` codes:
- INICIAL = 0
- ESPERA_SEMENTE = 1
- SORTEIO = 2
- REVELA = 3
- FIM = 4

Transitions:
- **INICIAL**: `jogar` → ESPERA_SEMENTE. `botao` and `passa` are ignored.
- **ESPERA_SEMENTE**: on `botao`, the LFSR loads the seed → SORTEIO. `jogar` is ignored. If `botao` and `jogar` arrive together, `botao` wins.
- **SORTEIO**: every cycle the LFSR advances.
  - Candidate c = LFSR[`IDX_W`-1:0].
  - Accept c only if c < `N_JOGADORES`, `jogo_atual`[c] == 0, and `conta_lobos` < `N_LOBOS`.
  - On accept, set `jogo_atual`[c] and increment `conta_lobos`.
  - When registered `conta_lobos` == `N_LOBOS` → REVELA, with `jogador_vez` = 0.
  - `jogar`, `botao` and `passa` are ignored in this state.
- **REVELA**: `passa` increments `jogador_vez`. `passa` while `jogador_vez` == `N_JOGADORES`-1 → FIM; `jogador_vez` holds its last value. `jogar` is ignored.
- **FIM**: `jogar` → ESPERA_SEMENTE. On that transition `jogo_atual`, `conta_lobos` and `jogador_vez` are cleared.

LFSR:
- 16-bit Fibonacci, shift left.
- Feedback = b15^b13^b12^b10, inserted at b0.
- A seed of 0 is replaced by 16'h0001 (lockup guard).

Seed counter `CS`:
- 16-bit free-running counter, wraps 16'hFFFF → 0.
- Cleared only by `reset`.

Outputs:
- `papel_vez` = `jogo_atual`[`jogador_vez`] in REVELA, else 0.
- `pronto` = 1 in REVELA or FIM.
- `fim` = 1 in FIM.
- `jogo_atual` keeps its value through REVELA and FIM.

## Timing
- Reset values:
  - State is INICIAL and `db_estado` = 0.
  - `jogo_atual` = 0, `jogador_vez` = 0, `papel_vez` = 0, `pronto` = 0, `fim` = 0.
  - `CS` = 0, LFSR = 16'h0001, `conta_lobos` = 0.
- `reset` takes effect immediately in any state, including mid-SORTEIO. No partial mask survives.
- All outputs are registered or decoded from registered state. There are no combinational input-to-output paths.
- `botao` at edge k: the LFSR holds the seed after edge k, and the first candidate is evaluated in cycle k+1.
- Dealing latency is variable. It is at least `N_LOBOS`+1 cycles after entering SORTEIO and is bounded by 65535×`N_LOBOS` cycles.
- At most one acceptance per cycle.
- `passa` at edge k: `jogador_vez` and `papel_vez` update after edge k.

## Configuration
- `SORTEIO_SEMENTE_FIXA_EN` defined:
  - The seed is always `SEMENTE_FIXA`, making games deterministic for verification.
  - `botao` still triggers ESPERA_SEMENTE → SORTEIO.
  - `CS` is not instantiated.
- Not defined: the seed is the value of `CS` at the `botao` edge.

## Test plan
1. **Reset:** assert `reset` → `db_estado`=0, `jogo_atual`=0, `pronto`=0, `fim`=0.
2. **Default deal:** N=10, L=2. Pulse `jogar`, then `botao` → within the bound, `db_estado`=3, `pronto`=1, popcount(`jogo_atual`)=2, `jogador_vez`=0.
3. **Full reveal:** in REVELA, send 10 `passa` pulses → `jogador_vez` steps 0..9; each `papel_vez` equals `jogo_atual`[i]; the 10th pulse gives `db_estado`=4, `fim`=1, `jogador_vez`=9.
4. **Determinism:** with `SORTEIO_SEMENTE_FIXA_EN` and `SEMENTE_FIXA`=16'h0000, play two games via FIM→`jogar`→`botao` → identical `jogo_atual` both times, no lockup, and the mask is cleared between games.
5. **Dense deal and boundary:** N=4, L=3 → popcount(`jogo_atual`)=3. Also `jogar` and `botao` together in ESPERA_SEMENTE → enters SORTEIO.
6. **Reset mid-deal:** assert `reset` in SORTEIO → `db_estado`=0 and `jogo_atual`=0 immediately. A new `jogar`/`botao` then completes a normal deal.
